// File: rtl/gear_acc_ctrl.sv
// Streaming accumulator sequencer: folds a job of operands into a running sum
// through an external combinational gear adder and hands back sum + signed overflow.
module gear_acc_ctrl #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  output logic             o_add_carry,
  input  logic [WIDTH-1:0] i_add_sum,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf,
  input  logic             i_ready,
  output logic             o_busy,
  output logic [LEN_W-1:0] o_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len;
  logic             ovf;

  logic beat, last, beat_ovf;

  // ready is a pure state decode, so there is no combinational i_valid->o_ready path
  assign beat     = (state == S_ACC) && i_valid;
  assign last     = (count == len - LEN_W'(1));
  assign beat_ovf = (i_data[WIDTH-1] == acc[WIDTH-1]) &&
                    (i_add_sum[WIDTH-1] != i_data[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      count <= '0;
      len   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            len   <= i_len;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= (i_len != '0) ? S_ACC : S_DONE;
          end
        end
        S_ACC: begin
          if (beat) begin
            acc   <= i_add_sum;
            count <= count + LEN_W'(1);
            ovf   <= ovf | beat_ovf;
            if (last) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ready     = (state == S_ACC);
  assign o_valid     = (state == S_DONE);
  assign o_busy      = (state != S_IDLE);
  assign o_add_a     = i_data;
  assign o_add_b     = acc;
  assign o_add_carry = 1'b0;
  assign o_sum       = o_valid ? acc : '0;
  assign o_ovf       = o_valid & ovf;
  assign o_count     = count;

endmodule

// File: doc/gear_acc_ctrl.md
Name: gear_acc_ctrl

Overview:
- Sequencer that owns one combinational 2's-complement gear adder instance (R/P-configured, Carry tied low) and uses it as a streaming accumulator for systolic-array partial sums.
- Accepts a job length, pulls that many operands over a valid/ready stream and folds each into a running sum through the external adder.
- Presents the final sum and a sticky signed-overflow flag on a valid/ready result port.
- Sits between a PE column's product stream and the output buffer.

Parameters:
- WIDTH, 16: operand, accumulator and adder width (must match the adder's WIDTH_A/WIDTH_B).
- LEN_W, 8: width of the job-length field; maximum job is 2^LEN_W-1 operands.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- i_start  input  1  job start pulse; sampled only in IDLE.
- i_len  input  LEN_W  number of operands in the job; sampled with i_start.
- i_valid  input  1  operand valid.
- i_data  input  WIDTH  operand, 2's complement.
- o_ready  output  1  operand ready.
- o_add_a  output  WIDTH  adder operand A (driven with i_data).
- o_add_b  output  WIDTH  adder operand B (driven with the accumulator).
- o_add_carry  output  1  adder carry-in, constant 0.
- i_add_sum  input  WIDTH  adder result, combinational, same cycle.
- o_valid  output  1  result valid.
- o_sum  output  WIDTH  accumulated result.
- o_ovf  output  1  sticky signed overflow for the job; valid with o_valid.
- i_ready  input  1  result consumer ready.
- o_busy  output  1  high in ACC or DONE.
- o_count  output  LEN_W  operands accepted so far in the current job.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, acc=0, count=0, len=0, ovf=0.
  - o_ready=0, o_valid=0, o_busy=0, o_sum=0, o_ovf=0.
  - Reset mid-job abandons the job with no output; there is no residual state.
- States: IDLE, ACC, DONE. All outputs are registered or decoded from state (no i_valid→o_ready path).
- IDLE:
  - On i_start=1: latch len=i_len, clear acc, count and ovf.
  - i_len≠0 → ACC; i_len=0 → DONE with sum 0, ovf 0.
- ACC:
  - o_ready=1. o_add_a=i_data, o_add_b=acc, o_add_carry=0.
  - A beat fires when i_valid&o_ready. On a beat: acc<=i_add_sum, count<=count+1, and ovf<=ovf | (a[MSB]==b[MSB] && sum[MSB]!=a[MSB]).
  - When the firing beat has count==len-1: transition to DONE. In DONE, o_sum reflects the updated acc.
  - No beat means acc, count and ovf hold.
- DONE:
  - o_valid=1, o_ready=0, o_sum=acc, o_ovf=ovf.
  - o_valid stays high and data stays stable until i_ready=1. On that cycle: → IDLE, o_valid drops next cycle.
- Arithmetic:
  - Sum is modulo 2^WIDTH (wrap, no saturation).
  - The block trusts i_add_sum as delivered. With an approximate R/P configuration, result = iterated adder output, not the exact sum.
  - The controller does not correct approximation error.
- Boundary conditions:
  - i_start outside IDLE is ignored.
  - i_len and i_data changes while idle have no effect.
  - Minimum turnaround: DONE→IDLE costs one cycle, so a new i_start is accepted earliest the cycle after result acceptance.
  - Job of len=1 completes in DONE one cycle after its single beat.
  - Throughput in ACC is one operand per cycle.
  - Latency from the last beat to o_valid is 1 cycle.
  - len=2^LEN_W-1: count reaches len-1 without wrapping.
- o_busy = (state!=IDLE).
- o_count resets to 0 on each accepted start.

Test Plan:
- Exact adder config (R=P so the adder is exact), start len=3, stream 5, 10, 0x0FFF back-to-back → o_valid one cycle after third beat, o_sum=0x100E, o_ovf=0, o_count=3.
- len=4, operands −10, 5, 20, −5 with i_valid gaps of 2 idle cycles between beats → o_sum=0x000A, o_ovf=0; acc holds during gaps.
- len=2, operands 0x7FFF, 0x0001 → o_sum=0x8000, o_ovf=1. Next job len=2, 0x8000, 0x8000 → o_sum=0x0000, o_ovf=1 (flag recomputed per job).
- len=0 start → DONE next cycle, o_sum=0, o_ovf=0, o_ready never asserted. Hold i_ready=0 five cycles → o_valid and o_sum stable. Then i_ready=1 → IDLE; i_start pulses during DONE are ignored.
- Assert rst asynchronously mid-job (after 2 of 4 beats, between clock edges) → outputs clear immediately. A subsequent len=1 job with 0xFFFF yields o_sum=0xFFFF.
- Random: 20 jobs of random len 1..16 with random data and random i_valid/i_ready backpressure → o_sum matches a model folding i_add_sum (exact config: modular sum); o_ovf matches model.
